// File: rtl/mem_pkg.sv
// Shared definitions for the memory copy engine: default widths, memory size, FSM states.
package mem_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_LEN_W     = 16;
  localparam int unsigned DEF_MEM_WORDS = 6536;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD,
    ST_WR,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/mem_range_check.sv
// Combinational job qualification: bounds check and copy direction for a latched job.
module mem_range_check
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              range_err,
  output logic              overlap_desc
);

  localparam int unsigned XW = ADDR_W + 1;

  logic [XW-1:0] src_end;
  logic [XW-1:0] dst_end;
  logic [XW-1:0] limit;

  // One extra bit so src+len never wraps back into the legal range.
  always_comb begin
    limit        = XW'(MEM_WORDS);
    src_end      = XW'(src) + XW'(len);
    dst_end      = XW'(dst) + XW'(len);
    range_err    = (src_end > limit) || (dst_end > limit);
    overlap_desc = (dst > src) && (XW'(dst) < src_end);
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Word copy initiator on the data-memory port: one read then one write per word,
// descending when the destination overlaps the tail of the source.
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  state_t            state;
  logic [ADDR_W-1:0] job_src;
  logic [ADDR_W-1:0] job_dst;
  logic [LEN_W-1:0]  job_len;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic              desc;

  logic              range_err;
  logic              overlap_desc;
  logic [ADDR_W-1:0] first_src;
  logic [ADDR_W-1:0] first_dst;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;
  logic              last_word;

  mem_range_check #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .MEM_WORDS(MEM_WORDS)
  ) u_range_check (
    .src         (job_src),
    .dst         (job_dst),
    .len         (job_len),
    .range_err   (range_err),
    .overlap_desc(overlap_desc)
  );

  // Start addresses for the chosen direction and the per-word address step.
  always_comb begin
    first_src = job_src;
    first_dst = job_dst;
    if (overlap_desc) begin
      first_src = job_src + ADDR_W'(job_len) - ADDR_W'(1);
      first_dst = job_dst + ADDR_W'(job_len) - ADDR_W'(1);
    end
    src_nxt   = desc ? cur_src - ADDR_W'(1) : cur_src + ADDR_W'(1);
    dst_nxt   = desc ? cur_dst - ADDR_W'(1) : cur_dst + ADDR_W'(1);
    last_word = (words_done + LEN_W'(1)) == job_len;
  end

  // Write data is the memory's registered read word, which it holds while read is low.
  assign mem_datain = mem_write ? mem_dataout : DATA_W'(0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      words_done  <= LEN_W'(0);
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= ADDR_W'(0);
      job_src     <= ADDR_W'(0);
      job_dst     <= ADDR_W'(0);
      job_len     <= LEN_W'(0);
      cur_src     <= ADDR_W'(0);
      cur_dst     <= ADDR_W'(0);
      desc        <= 1'b0;
    end else begin
      done      <= 1'b0;
      error     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            job_src    <= src_addr;
            job_dst    <= dst_addr;
            job_len    <= length;
            words_done <= LEN_W'(0);
            busy       <= 1'b1;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (job_len == LEN_W'(0)) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (range_err) begin
            error <= 1'b1;
            state <= ST_ERR;
          end else begin
            desc        <= overlap_desc;
            cur_src     <= first_src;
            cur_dst     <= first_dst;
            mem_read    <= 1'b1;
            mem_address <= first_src;
            state       <= ST_RD;
          end
        end
        ST_RD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            mem_write   <= 1'b1;
            mem_address <= cur_dst;
            state       <= ST_WR;
          end
        end
        ST_WR: begin
          // The write in flight always lands; abort only stops the next read.
          words_done <= words_done + LEN_W'(1);
          cur_src    <= src_nxt;
          cur_dst    <= dst_nxt;
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (last_word) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            mem_read    <= 1'b1;
            mem_address <= src_nxt;
            state       <= ST_RD;
          end
        end
        ST_DONE, ST_ERR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a word memory responder plus a memmove reference of its contents.
module tb_mem_copy_engine;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned NW = 6536;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] length;
  logic          abort;
  logic          busy;
  logic          done;
  logic          error;
  logic [LW-1:0] words_done;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout = '0;

  logic [DW-1:0] mem     [NW];
  logic [DW-1:0] ref_mem [NW];

  int checks   = 0;
  int failures = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always #5 clock = ~clock;

  mem_copy_engine dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .words_done (words_done),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_datain (mem_datain),
    .mem_dataout(mem_dataout)
  );

  // Data memory: write on the edge, registered read data that holds between reads.
  always @(posedge clock) begin
    if (mem_write && mem_address < NW) mem[mem_address] = mem_datain;
    if (mem_read && mem_address < NW) mem_dataout <= mem[mem_address];
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_copy(input int s, input int d, input int l);
    logic [DW-1:0] tmp[$];
    for (int i = 0; i < l; i++) tmp.push_back(ref_mem[s+i]);
    for (int i = 0; i < l; i++) ref_mem[d+i] = tmp[i];
  endtask

  task automatic cmp_region(input string tag, input int base, input int n);
    int bad = 0;
    for (int a = base - 1; a <= base + n; a++)
      if (a >= 0 && a < int'(NW) && mem[a] !== ref_mem[a]) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic launch(input int s, input int d, input int l);
    @(negedge clock);
    src_addr = AW'(s);
    dst_addr = AW'(d);
    length   = LW'(l);
    start    = 1'b1;
  endtask

  // Returns the cycle (1 = first cycle after the accept edge) in which done/error shows.
  task automatic wait_end(input string tag, output int cyc, output logic was_err);
    cyc     = -1;
    was_err = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0;
        check({tag, "_busy_check"}, 64'(busy), 64'd1);
      end
      if (done || error) begin
        cyc     = k;
        was_err = error;
        break;
      end
    end
  endtask

  task automatic run_job(input string tag, input int s, input int d, input int l);
    int   r0, w0, b0, cyc, exp_cyc, nacc;
    logic was_err, exp_err;
    r0 = rd_cnt; w0 = wr_cnt; b0 = both_cnt;
    exp_err = (l != 0) && ((s + l > int'(NW)) || (d + l > int'(NW)));
    exp_cyc = (l == 0 || exp_err) ? 2 : 2 * l + 2;
    nacc    = (l == 0 || exp_err) ? 0 : l;
    launch(s, d, l);
    wait_end(tag, cyc, was_err);
    check({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_errflag"}, 64'(was_err), 64'(exp_err));
    check({tag, "_busy_end"}, 64'(busy), 64'd1);
    check({tag, "_words"}, 64'(words_done), 64'(nacc));
    @(negedge clock);
    check({tag, "_pulse"}, {62'd0, done, error}, 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_reads"}, 64'(rd_cnt - r0), 64'(nacc));
    check({tag, "_writes"}, 64'(wr_cnt - w0), 64'(nacc));
    check({tag, "_both"}, 64'(both_cnt - b0), 64'd0);
    if (nacc != 0) model_copy(s, d, l);
    cmp_region({tag, "_mem"}, (d < int'(NW)) ? d : int'(NW) - 1, (l < 40) ? l : 40);
  endtask

  initial begin
    int   s, d, l, cyc, w0, d0, e0, bad;
    logic was_err;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    for (int i = 0; i < int'(NW); i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    check("rst_datain", 64'(mem_datain), 64'd0);
    check("rst_words", 64'(words_done), 64'd0);
    reset = 1'b0;

    // Plain ascending copy
    for (int i = 0; i < 4; i++) begin
      mem[10+i]     = 32'hA0A0_0000 + 32'(i);
      ref_mem[10+i] = 32'hA0A0_0000 + 32'(i);
    end
    run_job("asc4", 10, 100, 4);
    check("asc4_word0", 64'(mem[100]), 64'h A0A0_0000);
    check("asc4_word3", 64'(mem[103]), 64'h A0A0_0003);

    // Overlapping copy needs descending order
    run_job("ovl4", 10, 12, 4);
    check("ovl4_word12", 64'(mem[12]), 64'h A0A0_0000);
    check("ovl4_word15", 64'(mem[15]), 64'h A0A0_0003);

    run_job("len0", 32, 64, 0);
    run_job("range", 6534, 50, 4);
    run_job("edge_ok", 6532, 6000, 4);

    // Abort in the second read: one word lands, no done/error
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    launch(200, 300, 4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 4) begin
        check("abort_in_rd", 64'(mem_read), 64'd1);
        abort = 1'b1;
      end
      if (k == 5) begin
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_words", 64'(words_done), 64'd1);
      end
    end
    check("abort_writes", 64'(wr_cnt - w0), 64'd1);
    check("abort_no_pulse", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
    ref_mem[300] = ref_mem[200];
    cmp_region("abort_mem", 300, 4);

    // Reset during the second word's write
    launch(400, 500, 4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 5) begin
        check("rstmid_in_wr", 64'(mem_write), 64'd1);
        reset = 1'b1;
      end
      if (k == 6) begin
        check("rstmid_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_words", 64'(words_done), 64'd0);
        reset = 1'b0;
      end
    end
    ref_mem[500] = ref_mem[400];
    ref_mem[501] = ref_mem[401];
    cmp_region("rstmid_mem", 500, 4);
    run_job("after_rst", 400, 520, 5);

    // A second start while busy must not disturb the running job
    launch(600, 700, 6);
    cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 3) begin
        start = 1'b1; src_addr = 1000; dst_addr = 1100; length = 2;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        cyc = k;
        break;
      end
    end
    check("busy_start_cycle", 64'(cyc), 64'd14);
    model_copy(600, 700, 6);
    cmp_region("busy_start_mem", 700, 6);
    cmp_region("busy_start_other", 1100, 2);
    @(negedge clock);

    // Randomised jobs, biased toward overlaps and the top of memory
    for (int j = 0; j < 24; j++) begin
      s = $urandom_range(0, 3000);
      l = $urandom_range(0, 24);
      case ($urandom_range(0, 3))
        0: d = s + $urandom_range(0, 6) - 3;
        1: d = int'(NW) - $urandom_range(0, 30);
        default: d = $urandom_range(0, 6000);
      endcase
      if (d < 0) d = 0;
      if ($urandom_range(0, 7) == 0) s = int'(NW) - $urandom_range(0, 30);
      run_job($sformatf("rnd%0d", j), s, d, l);
    end

    bad = 0;
    for (int i = 0; i < int'(NW); i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final_mem", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
